mem_access_sequencer: RTL and testbench

//  Memory-port stage directly downstream of the multi-cycle microcode controller.
//  - Turns the controller's level-held mem_read/mem_write/i_or_d/ir_write strobes into one

---
 rtl/mem_access_sequencer.sv | 117 +++++++++++
 tb/tb_mem_access_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Memory-port sequencer: one handshaked access per controller strobe rise,
// latching read data into IR or MDR, with timeout and sticky error.
module mem_access_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              i_or_d,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       req;
  logic       req_q;
  logic       both;
  logic       accept;
  logic       to_hit;
  logic [7:0] cnt;
  logic       kind_wr;
  logic       dest_ir;

  assign req    = mem_read | mem_write;
  assign both   = mem_read & mem_write;
  assign accept = (state == IDLE) && req && !req_q;
  assign to_hit = (cnt == 8'(TIMEOUT - 1));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && !both) state_nx = ACCESS;
      ACCESS:  if (mem_ack || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= 1'b0;
      cnt       <= '0;
      kind_wr   <= 1'b0;
      dest_ir   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      instr     <= '0;
      mdr       <= '0;
      err       <= 1'b0;
    end else begin
      req_q <= req;
      unique case (state)
        IDLE: begin
          if (accept && both) begin
            err <= 1'b1;
          end else if (accept) begin
            mem_addr  <= i_or_d ? alu_out : pc;
            mem_wdata <= wdata_in;
            kind_wr   <= mem_write;
            dest_ir   <= ir_write;
            cnt       <= '0;
            mem_rd_en <= mem_read;
            mem_wr_en <= mem_write;
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          // ack beats a simultaneous timeout
          if (mem_ack) begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            if (!kind_wr && dest_ir)  instr <= mem_rdata;
            if (!kind_wr && !dest_ir) mdr   <= mem_rdata;
          end else if (to_hit) begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: vector table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_access_sequencer;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic          i_or_d = 1'b0;
  logic          ir_write = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] alu_out = '0;
  logic [DW-1:0] wdata_in = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] instr;
  logic [DW-1:0] mdr;
  logic          busy;
  logic          done;
  logic          err;

  int n_pass = 0;
  int n_total = 0;

  mem_access_sequencer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .i_or_d   (i_or_d),
    .ir_write (ir_write),
    .pc       (pc),
    .alu_out  (alu_out),
    .wdata_in (wdata_in),
    .mem_addr (mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .instr    (instr),
    .mdr      (mdr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // age = ACCESS cycles elapsed for the in-flight access (0: none)
  int          m_age;
  bit          m_done;
  bit          m_err;
  bit          m_wr;
  bit          m_dest;
  bit          m_prev;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_instr;
  logic [15:0] m_mdr;

  function automatic void model_reset();
    m_age = 0; m_done = 0; m_err = 0; m_wr = 0; m_dest = 0;
    m_prev = 0; m_addr = '0; m_wdata = '0; m_instr = '0; m_mdr = '0;
  endfunction

  function automatic void model_step();
    bit r;
    r = mem_read | mem_write;
    if (m_age > 0) begin
      if (mem_ack) begin
        if (!m_wr && m_dest)  m_instr = mem_rdata;
        if (!m_wr && !m_dest) m_mdr = mem_rdata;
        m_age = 0;
        m_done = 1;
      end else if (m_age == TO) begin
        m_err = 1;
        m_age = 0;
        m_done = 1;
      end else begin
        m_age++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (r && !m_prev) begin
      if (mem_read && mem_write) begin
        m_err = 1;
      end else begin
        m_addr = i_or_d ? alu_out : pc;
        m_wdata = wdata_in;
        m_wr = mem_write;
        m_dest = ir_write;
        m_age = 1;
      end
    end
    m_prev = r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cmp_model();
    chk("rd_en", 32'(mem_rd_en), 32'(m_age > 0 && !m_wr));
    chk("wr_en", 32'(mem_wr_en), 32'(m_age > 0 && m_wr));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_age > 0 || m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("addr", 32'(mem_addr), 32'(m_addr));
    chk("wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("mdr", 32'(mdr), 32'(m_mdr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    mem_read = 0;
    mem_write = 0;
    mem_ack = 0;
    reset_n = 0;
    #2;
    model_reset();
    reset_n = 1;
  endtask

  typedef struct {
    logic        rd, wr, iod, irw, ack;
    logic [15:0] alu, rdata;
    logic        e_rd, e_wr, e_done, e_busy;
    logic [15:0] e_addr, e_instr, e_mdr;
  } vec_t;

  function automatic vec_t mk(
    logic rd, logic wr, logic iod, logic irw, logic ack,
    logic [15:0] alu, logic [15:0] rdata,
    logic e_rd, logic e_wr, logic e_done, logic e_busy,
    logic [15:0] e_addr, logic [15:0] e_instr, logic [15:0] e_mdr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.iod = iod; v.irw = irw; v.ack = ack;
    v.alu = alu; v.rdata = rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_done = e_done; v.e_busy = e_busy;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_mdr = e_mdr;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int cnt;
    int seen;
    int k;

    tbl[0]  = mk(1,0,0,1,0, 16'h0200,16'h0000, 1,0,0,1, 16'h0010,16'h0000,16'h0000);
    tbl[1]  = mk(1,0,0,1,0, 16'h0200,16'h0000, 1,0,0,1, 16'h0010,16'h0000,16'h0000);
    tbl[2]  = mk(1,0,0,1,0, 16'h0200,16'h0000, 1,0,0,1, 16'h0010,16'h0000,16'h0000);
    tbl[3]  = mk(1,0,0,1,1, 16'h0200,16'h6A01, 0,0,1,1, 16'h0010,16'h6A01,16'h0000);
    tbl[4]  = mk(1,0,0,1,0, 16'h0200,16'h0000, 0,0,0,0, 16'h0010,16'h6A01,16'h0000);
    tbl[5]  = mk(1,0,0,1,1, 16'h0200,16'hFFFF, 0,0,0,0, 16'h0010,16'h6A01,16'h0000);
    tbl[6]  = mk(0,0,0,1,0, 16'h0200,16'h0000, 0,0,0,0, 16'h0010,16'h6A01,16'h0000);
    tbl[7]  = mk(1,0,1,0,0, 16'h0200,16'h0000, 1,0,0,1, 16'h0200,16'h6A01,16'h0000);
    tbl[8]  = mk(1,0,1,0,1, 16'h0200,16'hBEEF, 0,0,1,1, 16'h0200,16'h6A01,16'hBEEF);
    tbl[9]  = mk(0,0,1,0,0, 16'h0200,16'h0000, 0,0,0,0, 16'h0200,16'h6A01,16'hBEEF);
    tbl[10] = mk(0,1,1,0,0, 16'h0300,16'h0000, 0,1,0,1, 16'h0300,16'h6A01,16'hBEEF);
    tbl[11] = mk(0,1,1,0,1, 16'h0300,16'h1111, 0,0,1,1, 16'h0300,16'h6A01,16'hBEEF);
    tbl[12] = mk(0,1,1,0,0, 16'h0300,16'h0000, 0,0,0,0, 16'h0300,16'h6A01,16'hBEEF);
    tbl[13] = mk(0,1,1,0,0, 16'h0300,16'h0000, 0,0,0,0, 16'h0300,16'h6A01,16'hBEEF);
    tbl[14] = mk(0,1,1,0,1, 16'h0300,16'h2222, 0,0,0,0, 16'h0300,16'h6A01,16'hBEEF);
    tbl[15] = mk(0,0,1,0,0, 16'h0300,16'h0000, 0,0,0,0, 16'h0300,16'h6A01,16'hBEEF);

    model_reset();
    #3;
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    #9;
    reset_n = 1;

    pc = 16'h0010;
    wdata_in = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      mem_read = tbl[i].rd;
      mem_write = tbl[i].wr;
      i_or_d = tbl[i].iod;
      ir_write = tbl[i].irw;
      mem_ack = tbl[i].ack;
      alu_out = tbl[i].alu;
      mem_rdata = tbl[i].rdata;
      tick();
      chk($sformatf("v%0d_rd_en", i), 32'(mem_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_wr_en", i), 32'(mem_wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_instr", i), 32'(instr), 32'(tbl[i].e_instr));
      chk($sformatf("v%0d_mdr", i), 32'(mdr), 32'(tbl[i].e_mdr));
    end
    chk("store_wdata", 32'(mem_wdata), 32'h1234);

    // timeout with no ack
    do_reset();
    pc = 16'h0040; i_or_d = 0; ir_write = 1; mem_ack = 0;
    mem_read = 1;
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (mem_rd_en) cnt++;
      if (done) seen = 1;
    end
    chk("to_rd_cycles", 32'(cnt), 32'(TO));
    chk("to_done", 32'(seen), 32'h1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_instr", 32'(instr), 32'h0);
    mem_read = 0;
    tick();

    // ack on the last allowed cycle wins over timeout
    do_reset();
    mem_read = 1;
    mem_rdata = 16'hC0DE;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("edge_rd_en", 32'(mem_rd_en), 32'h1);
    mem_ack = 1;
    tick();
    chk("edge_done", 32'(done), 32'h1);
    chk("edge_err", 32'(err), 32'h0);
    chk("edge_instr", 32'(instr), 32'hC0DE);
    mem_ack = 0;
    mem_read = 0;
    tick();

    // both strobes together
    do_reset();
    mem_read = 1;
    mem_write = 1;
    tick();
    chk("both_err", 32'(err), 32'h1);
    chk("both_rd_en", 32'(mem_rd_en), 32'h0);
    chk("both_wr_en", 32'(mem_wr_en), 32'h0);
    chk("both_busy", 32'(busy), 32'h0);
    tick();
    mem_read = 0;
    mem_write = 0;
    tick();

    // reset during ACCESS, then a stale ack
    do_reset();
    pc = 16'h0077;
    mem_read = 1;
    tick();
    tick();
    reset_n = 0;
    #1;
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    mem_read = 0;
    mem_ack = 1;
    mem_rdata = 16'hDEAD;
    #1;
    model_reset();
    reset_n = 1;
    tick();
    chk("late_ack_instr", 32'(instr), 32'h0);
    mem_ack = 0;
    tick();
    mem_read = 1;
    tick();
    tick();
    mem_ack = 1;
    mem_rdata = 16'h5555;
    tick();
    chk("post_rst_done", 32'(done), 32'h1);
    chk("post_rst_instr", 32'(instr), 32'h5555);
    chk("post_rst_addr", 32'(mem_addr), 32'h0077);
    mem_ack = 0;
    mem_read = 0;
    tick();

    // random traffic
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(3) == 0) begin
          k = int'($urandom_range(39));
          mem_read = (k == 0) || (k < 16);
          mem_write = (k == 0) || (k >= 16 && k < 28);
        end
        i_or_d = 1'($urandom);
        ir_write = 1'($urandom);
        pc = 16'($urandom);
        alu_out = 16'($urandom);
        wdata_in = 16'($urandom);
        mem_rdata = 16'($urandom);
        mem_ack = ($urandom_range(3) == 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
